// File: rtl/sd_cmd_pkg.sv
// ---------------------------------------------------------------------------
// sd_cmd_pkg
//  Shared definitions for the SD CMD-line transmitter and receiver/checker:
//  field widths, CRC7 polynomial, bit-counter constants, FSM state encoding
//  and the single-bit CRC7 step function used by the serial LFSR.
// ---------------------------------------------------------------------------
package sd_cmd_pkg;

  localparam int IDX_W   = 6;                  // command index width
  localparam int ARG_W   = 32;                 // command argument width
  localparam int CRC_W   = 7;                  // CRC7 width
  localparam int PAY_W   = IDX_W + ARG_W + 2;  // start + transmission + index + argument
  localparam int FRAME_W = PAY_W + CRC_W + 1;  // payload + CRC7 + end bit

  // x^7 + x^3 + 1 (the x^7 term is implicit in the shift)
  localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

  // The bit counter holds the number of frame bits already placed on the
  // line; it runs 1..FRAME_W-1 and is cleared on return to IDLE.
  localparam int                CNT_W       = 6;
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_PAY_END = CNT_W'(PAY_W);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(FRAME_W - 1);

  // The state names what is on the line during the current cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC     = 2'd2,
    STOP    = 2'd3
  } state_t;

  // One step of the serial CRC7 LFSR: fold the incoming bit into the MSB
  // feedback and shift left.
  function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc,
                                                 input logic             bit_in);
    logic fb;
    fb = bit_in ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// ---------------------------------------------------------------------------
// sd_crc7
//  Serial CRC7 generator/checker (x^7 + x^3 + 1), one bit per clock.
//  A clear in the same cycle as shift_en restarts the CRC from zero and
//  folds in bit_in, so the first bit of a frame is never lost.
// Ports
//  sd_clock  in   1      clock, rising edge
//  reset     in   1      synchronous, active-low
//  clear     in   1      restart CRC from zero
//  shift_en  in   1      fold bit_in into the CRC this cycle
//  bit_in    in   1      serial data bit
//  crc       out  CRC_W  current CRC register
// ---------------------------------------------------------------------------
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic             sd_clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] w_seed;
  logic [CRC_W-1:0] w_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_seed = r_crc;
    if (clear) w_seed = '0;
    w_next = crc7_step(w_seed, bit_in);
  end

  // NOTE: clocked state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge sd_clock) begin
    if (!reset) begin
      r_crc <= '0;
    end else if (shift_en) begin
      r_crc <= w_next;
    end else if (clear) begin
      r_crc <= '0;
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/wrapper_paralelo_serial.sv
// ---------------------------------------------------------------------------
// wrapper_paralelo_serial
//  Host-side SD CMD-line transmitter. Captures a command index and argument,
//  builds the 48-bit frame {0, 1, index, argument, CRC7, 1} and shifts it
//  out MSB first, one bit per sd_clock, with the pad output-enable high for
//  the whole frame. complete pulses for one cycle after the end bit, and
//  that cycle already accepts the next request.
// Ports
//  sd_clock   in   1      clock, all state changes on rising edge
//  reset      in   1      synchronous, active-low
//  enable     in   1      start request, sampled only while ready=1
//  cmd_index  in   IDX_W  command index, captured on accept
//  argument   in   ARG_W  command argument, captured on accept
//  serial     out  1      CMD line data, idles high
//  serial_oe  out  1      pad drive enable, high while a frame is on the line
//  ready      out  1      idle and able to accept enable
//  complete   out  1      one-cycle pulse after the end bit
// ---------------------------------------------------------------------------
module wrapper_paralelo_serial
  import sd_cmd_pkg::*;
(
  input  logic             sd_clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [IDX_W-1:0] cmd_index,
  input  logic [ARG_W-1:0] argument,
  output logic             serial,
  output logic             serial_oe,
  output logic             ready,
  output logic             complete
);

  state_t           r_state;
  logic [PAY_W-1:0] r_shift;     // bits still to be driven, next one at the MSB
  logic [CNT_W-1:0] r_cnt;       // frame bits already placed on the line
  logic             r_serial;
  logic             r_oe;
  logic             r_ready;
  logic             r_complete;

  logic [PAY_W-1:0] w_payload;
  logic             w_accept;
  logic             w_crc_shift;
  logic             w_crc_bit;
  logic [CRC_W-1:0] w_crc;

  always_comb begin
    w_payload   = {1'b0, 1'b1, cmd_index, argument};
    w_accept    = (r_state == IDLE) && enable;
    w_crc_shift = 1'b0;
    w_crc_bit   = r_shift[PAY_W-1];
    // The CRC covers exactly the bits driven: the start bit on accept, then
    // each payload bit until all PAY_W have gone out.
    if (w_accept) begin
      w_crc_shift = 1'b1;
      w_crc_bit   = w_payload[PAY_W-1];
    end else if ((r_state == PAYLOAD) && (r_cnt != CNT_PAY_END)) begin
      w_crc_shift = 1'b1;
    end
  end

  sd_crc7 u_crc7 (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clear    (w_accept),
    .shift_en (w_crc_shift),
    .bit_in   (w_crc_bit),
    .crc      (w_crc)
  );

  always_ff @(posedge sd_clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_serial   <= 1'b1;
      r_oe       <= 1'b0;
      r_ready    <= 1'b1;
      r_complete <= 1'b0;
    end else begin
      r_complete <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) begin
            // Start bit goes straight to the line; the shift register keeps
            // the remaining payload bits.
            r_serial <= w_payload[PAY_W-1];
            r_shift  <= {w_payload[PAY_W-2:0], 1'b0};
            r_oe     <= 1'b1;
            r_ready  <= 1'b0;
            r_cnt    <= CNT_ONE;
            r_state  <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_PAY_END) begin
            // Payload is fully folded into the CRC, which is now final and
            // no longer changes. Its MSB goes out now; the rest plus the end
            // bit are parked in the (empty) shift register behind it.
            r_serial <= w_crc[CRC_W-1];
            r_shift  <= {w_crc[CRC_W-2:0], 1'b1, {(PAY_W-CRC_W){1'b0}}};
            r_state  <= CRC;
          end else begin
            r_serial <= r_shift[PAY_W-1];
            r_shift  <= {r_shift[PAY_W-2:0], 1'b0};
          end
        end

        CRC: begin
          r_serial <= r_shift[PAY_W-1];
          r_shift  <= {r_shift[PAY_W-2:0], 1'b0};
          // Once all CRC bits are out, the bit now shifted onto the line is
          // the end bit.
          if (r_cnt == CNT_LAST) begin
            r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        STOP: begin
          r_serial   <= 1'b1;
          r_oe       <= 1'b0;
          r_ready    <= 1'b1;
          r_complete <= 1'b1;
          r_cnt      <= '0;
          r_shift    <= '0;
          r_state    <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign serial    = r_serial;
  assign serial_oe = r_oe;
  assign ready     = r_ready;
  assign complete  = r_complete;

endmodule

// File: tb/tb_wrapper_paralelo_serial.sv
// ---------------------------------------------------------------------------
// tb_wrapper_paralelo_serial
//  Directed bench for the SD CMD-line transmitter. A frame-level model
//  (CRC7 by polynomial long division, line position counted from the accept
//  edge) predicts every output every cycle; a collector reassembles frames
//  off the line so directed tests can compare them with literal frames.
// ---------------------------------------------------------------------------
module tb_wrapper_paralelo_serial;

  logic        sd_clock;
  logic        reset;
  logic        enable;
  logic [5:0]  cmd_index;
  logic [31:0] argument;
  logic        serial;
  logic        serial_oe;
  logic        ready;
  logic        complete;

  wrapper_paralelo_serial dut (
    .sd_clock  (sd_clock),
    .reset     (reset),
    .enable    (enable),
    .cmd_index (cmd_index),
    .argument  (argument),
    .serial    (serial),
    .serial_oe (serial_oe),
    .ready     (ready),
    .complete  (complete)
  );

  initial begin
    sd_clock = 1'b0;
    forever #5 sd_clock = ~sd_clock;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // number of rising edges so far
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected frame: message {0,1,idx,arg}, CRC7 = remainder of msg*x^7
  // divided by x^7+x^3+1 (0x89), then end bit 1.
  function automatic logic [47:0] exp_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] msg;
    logic [46:0] rem;
    msg = {2'b01, idx, arg};
    rem = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (rem[i]) rem = rem ^ (47'h89 << (i - 7));
    end
    return {msg, rem[6:0], 1'b1};
  endfunction

  // ---------------- model: position on the line since the accept edge -----
  // pos 0: idle; pos 1..48: frame bit (48-pos) on the line; pos 49: complete.
  int          m_pos   = 0;
  logic [47:0] m_frame = '0;

  always @(posedge sd_clock) begin
    cyc++;
    if (!reset) begin
      m_pos = 0;
    end else if ((m_pos == 0 || m_pos == 49) && enable) begin
      m_frame = exp_frame(cmd_index, argument);
      m_pos   = 1;
    end else if (m_pos >= 1 && m_pos <= 48) begin
      m_pos++;
    end else begin
      m_pos = 0;
    end
  end

  // ---------------- compare process ----------------------------------------
  always @(negedge sd_clock) begin
    if (chk_en) begin
      logic e_serial, e_oe, e_ready, e_complete;
      e_serial   = 1'b1;
      e_oe       = 1'b0;
      e_ready    = 1'b1;
      e_complete = (m_pos == 49);
      if (m_pos >= 1 && m_pos <= 48) begin
        e_serial = m_frame[48 - m_pos];
        e_oe     = 1'b1;
        e_ready  = 1'b0;
      end
      check("serial",    64'(serial),    64'(e_serial));
      check("serial_oe", 64'(serial_oe), 64'(e_oe));
      check("ready",     64'(ready),     64'(e_ready));
      check("complete",  64'(complete),  64'(e_complete));
    end
  end

  // ---------------- collector: frames off the line -------------------------
  logic [47:0] frames[$];
  int          comp_at[$];
  int          aborts = 0;
  logic [47:0] cap    = '0;
  int          ncap   = 0;

  always @(negedge sd_clock) begin
    if (serial_oe === 1'b1) begin
      cap = {cap[46:0], serial};
      ncap++;
    end else if (ncap > 0) begin
      if (ncap == 48) frames.push_back(cap);
      else            aborts++;
      ncap = 0;
    end
    if (complete === 1'b1) comp_at.push_back(cyc);
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge sd_clock);
  endtask

  // Request one command; t0 is the edge count of the accept edge. Inputs are
  // scrambled afterwards: the frame must not follow them.
  task automatic send(input logic [5:0] idx, input logic [31:0] arg, output int t0);
    @(negedge sd_clock);
    enable    = 1'b1;
    cmd_index = idx;
    argument  = arg;
    @(negedge sd_clock);
    enable    = 1'b0;
    t0        = cyc;
    cmd_index = ~idx;
    argument  = ~arg;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k = 0;
    while (frames.size() < target && k < budget) begin
      tick(1);
      k++;
    end
    check("frame_timeout", 64'(frames.size()), 64'(target));
    tick(2);
  endtask

  task automatic clear_logs();
    frames.delete();
    comp_at.delete();
    aborts = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset     = 1'b0;
    enable    = 1'b0;
    cmd_index = '0;
    argument  = '0;

    // Model pinned against hand-computed frames.
    check("model_cmd0",  exp_frame(6'd0,  32'h0),      48'h40_0000_0000_95);
    check("model_cmd8",  exp_frame(6'd8,  32'h1AA),    48'h48_0000_01AA_87);
    check("model_cmd17", exp_frame(6'd17, 32'h0),      48'h51_0000_0000_55);

    // Test 1: reset, then reset low 3 cycles while idle.
    @(posedge sd_clock);
    @(negedge sd_clock);
    chk_en = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_serial",   64'(serial),    64'd1);
    check("rst_oe",       64'(serial_oe), 64'd0);
    check("rst_ready",    64'(ready),     64'd1);
    check("rst_complete", 64'(complete),  64'd0);
    tick(1);
    reset = 1'b1;
    tick(2);

    // Test 2: CMD0, argument 0.
    clear_logs();
    send(6'd0, 32'h0, t0);
    wait_frames(1, 80);
    if (frames.size() >= 1) check("t2_frame", frames[0], 48'h40_0000_0000_95);
    check("t2_complete_cnt", 64'(comp_at.size()), 64'd1);
    if (comp_at.size() >= 1) check("t2_complete_at", 64'(comp_at[0] - t0), 64'd48);
    check("t2_aborts", 64'(aborts), 64'd0);

    // Test 3: CMD8 0x1AA and CMD17 0.
    clear_logs();
    send(6'd8, 32'h0000_01AA, t0);
    wait_frames(1, 80);
    send(6'd17, 32'h0, t0);
    wait_frames(2, 80);
    if (frames.size() >= 2) begin
      check("t3_cmd8",  frames[0], 48'h48_0000_01AA_87);
      check("t3_cmd17", frames[1], 48'h51_0000_0000_55);
    end
    check("t3_complete_cnt", 64'(comp_at.size()), 64'd2);

    // Test 4: enable pulses mid-frame are ignored.
    clear_logs();
    send(6'd0, 32'h0, t0);
    while (cyc < t0 + 9) tick(1);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    while (cyc < t0 + 29) tick(1);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    wait_frames(1, 80);
    tick(3);
    if (frames.size() >= 1) check("t4_frame", frames[0], 48'h40_0000_0000_95);
    check("t4_frames",       64'(frames.size()),  64'd1);
    check("t4_complete_cnt", 64'(comp_at.size()), 64'd1);
    if (comp_at.size() >= 1) check("t4_complete_at", 64'(comp_at[0] - t0), 64'd48);

    // Test 5: reset mid-frame aborts it; a fresh CMD0 afterwards is exact.
    clear_logs();
    send(6'd0, 32'h0, t0);
    while (cyc < t0 + 19) tick(1);
    reset = 1'b0;
    tick(1);
    check("t5_serial", 64'(serial),    64'd1);
    check("t5_oe",     64'(serial_oe), 64'd0);
    check("t5_ready",  64'(ready),     64'd1);
    reset = 1'b1;
    tick(3);
    check("t5_aborts",       64'(aborts),         64'd1);
    check("t5_complete_cnt", 64'(comp_at.size()), 64'd0);
    send(6'd0, 32'h0, t0);
    wait_frames(1, 80);
    if (frames.size() >= 1) check("t5_frame", frames[0], 48'h40_0000_0000_95);
    check("t5_complete_cnt2", 64'(comp_at.size()), 64'd1);

    // Test 6: enable held high, CMD0 then CMD17 back-to-back.
    clear_logs();
    @(negedge sd_clock);
    enable    = 1'b1;
    cmd_index = 6'd0;
    argument  = 32'h0;
    @(negedge sd_clock);
    t0        = cyc;
    cmd_index = 6'd17;
    while (cyc < t0 + 49) tick(1);
    enable    = 1'b0;
    cmd_index = 6'h3F;
    argument  = 32'hFFFF_FFFF;
    wait_frames(2, 120);
    if (frames.size() >= 2) begin
      check("t6_frame0", frames[0], 48'h40_0000_0000_95);
      check("t6_frame1", frames[1], 48'h51_0000_0000_55);
    end
    check("t6_complete_cnt", 64'(comp_at.size()), 64'd2);
    if (comp_at.size() >= 2) begin
      check("t6_complete0_at", 64'(comp_at[0] - t0), 64'd48);
      check("t6_complete1_at", 64'(comp_at[1] - t0), 64'd97);
    end
    check("t6_aborts", 64'(aborts), 64'd0);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
